ddrphy_dll_update_arb: RTL and testbench

Arbitrates and sequences DLL update operations for the DDR PHY. There are two requesters:
- the PHY reset sequencer's one-shot update request/ack handshake during bring-up;
- a periodic drift-compensation timer that may only run while the memory controller is idle.

The block drives the DLL freeze/update pins in a fixed freeze -> update -> release sequence. It sits between the reset sequencer, the memory controller and the DLL hard macro.

---
 rtl/ddrphy_upd_pkg.sv | 22 ++
 rtl/ddrphy_dll_update_arb_if.sv | 27 ++
 rtl/ddrphy_sync_2ff.sv | 26 ++
 rtl/ddrphy_dll_update_arb.sv | 137 +++++++++++++
 tb/tb_ddrphy_dll_update_arb.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ddrphy_upd_pkg.sv
// Shared types and default constants for the DDR PHY DLL update arbiter.
// Holds the FSM state encoding, the requester source and the parameter defaults.
package ddrphy_upd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FREEZE   = 3'd1,
        ST_UPDATE   = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_ACK_HOLD = 3'd4
    } upd_state_e;

    typedef enum logic {
        SRC_RST = 1'b0,
        SRC_PER = 1'b1
    } upd_src_e;

    localparam int unsigned DEF_UPDATE_PERIOD = 8192;
    localparam int unsigned DEF_FREEZE_HOLD   = 4;
    localparam int unsigned DEF_UPD_PULSE     = 4;

endpackage

// File: rtl/ddrphy_dll_update_arb_if.sv
// Signal bundle between the DLL update arbiter and its surroundings
// (reset sequencer, memory controller, DLL hard macro).
interface ddrphy_dll_update_arb_if;

    logic       rst_req;
    logic       rst_ack;
    logic       periodic_en;
    logic       ctrl_idle;
    logic       dll_lock;
    logic       dll_freeze;
    logic       dll_update;
    logic       upd_busy;
    logic [7:0] upd_count;

    // Arbiter side
    modport slave (
        input  rst_req, periodic_en, ctrl_idle, dll_lock,
        output rst_ack, dll_freeze, dll_update, upd_busy, upd_count
    );

    // Environment side
    modport master (
        output rst_req, periodic_en, ctrl_idle, dll_lock,
        input  rst_ack, dll_freeze, dll_update, upd_busy, upd_count
    );

endinterface

// File: rtl/ddrphy_sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low clear.
module ddrphy_sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ddrphy_dll_update_arb.sv
// DLL update arbiter: serves reset-sequencer and periodic drift requests with a
// fixed freeze -> update -> release sequence on the DLL macro pins.
module ddrphy_dll_update_arb
    import ddrphy_upd_pkg::*;
#(
    parameter int unsigned UPDATE_PERIOD = DEF_UPDATE_PERIOD,
    parameter int unsigned FREEZE_HOLD   = DEF_FREEZE_HOLD,
    parameter int unsigned UPD_PULSE     = DEF_UPD_PULSE
) (
    input  logic                  clk,
    input  logic                  ddr_rstn_key,
    ddrphy_dll_update_arb_if.slave bus
);

    localparam logic [3:0]  FH_LAST  = 4'(FREEZE_HOLD - 1);
    localparam logic [3:0]  UP_LAST  = 4'(UPD_PULSE - 1);
    localparam logic [15:0] TMR_LAST = 16'(UPDATE_PERIOD - 1);

    upd_state_e  state_q, state_d;
    upd_src_e    src_q, src_d;
    logic [3:0]  phase_q, phase_d;
    logic [15:0] timer_q;
    logic        pending_q;
    logic [7:0]  count_q;
    logic        freeze_q, update_q, busy_q, ack_q;
    logic        lock_s;
    logic        done;

    ddrphy_sync_2ff #(.W(1)) u_lock_sync (
        .clk  (clk),
        .rstn (ddr_rstn_key),
        .d_i  (bus.dll_lock),
        .q_o  (lock_s)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        src_d   = src_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Reset sequencer wins and is not gated by controller idle
                if (bus.rst_req && lock_s) begin
                    state_d = ST_FREEZE;
                    src_d   = SRC_RST;
                    phase_d = '0;
                end else if (pending_q && bus.ctrl_idle && lock_s) begin
                    state_d = ST_FREEZE;
                    src_d   = SRC_PER;
                    phase_d = '0;
                end
            end
            ST_FREEZE: begin
                if (phase_q == FH_LAST) begin
                    state_d = ST_UPDATE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_UPDATE: begin
                if (phase_q == UP_LAST) begin
                    state_d = ST_RELEASE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_RELEASE: begin
                if (phase_q == FH_LAST) begin
                    done    = 1'b1;
                    phase_d = '0;
                    state_d = (src_q == SRC_RST && bus.rst_req) ? ST_ACK_HOLD : ST_IDLE;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_ACK_HOLD: begin
                if (!bus.rst_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they move on the entering edge
    always_ff @(posedge clk or negedge ddr_rstn_key) begin
        if (!ddr_rstn_key) begin
            state_q  <= ST_IDLE;
            src_q    <= SRC_RST;
            phase_q  <= '0;
            count_q  <= '0;
            freeze_q <= 1'b0;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            phase_q  <= phase_d;
            freeze_q <= (state_d inside {ST_FREEZE, ST_UPDATE, ST_RELEASE});
            update_q <= (state_d == ST_UPDATE);
            busy_q   <= (state_d inside {ST_FREEZE, ST_UPDATE, ST_RELEASE});
            ack_q    <= (state_d == ST_ACK_HOLD);
            if (done) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    // Any completed update refreshes the DLL, so it restarts the drift timer
    always_ff @(posedge clk or negedge ddr_rstn_key) begin
        if (!ddr_rstn_key) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else if (!bus.periodic_en || done) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else if (!pending_q) begin
            if (timer_q == TMR_LAST) begin
                timer_q   <= '0;
                pending_q <= 1'b1;
            end else begin
                timer_q <= timer_q + 16'd1;
            end
        end
    end

    assign bus.dll_freeze = freeze_q;
    assign bus.dll_update = update_q;
    assign bus.upd_busy   = busy_q;
    assign bus.rst_ack    = ack_q;
    assign bus.upd_count  = count_q;

endmodule

// File: tb/tb_ddrphy_dll_update_arb.sv
// Self-checking bench for ddrphy_dll_update_arb: directed scenarios plus random
// traffic, every cycle compared against a sequence-position reference model.
module tb_ddrphy_dll_update_arb;

    localparam int PER = 64;
    localparam int FH  = 4;
    localparam int UP  = 4;
    localparam int LEN = 2 * FH + UP;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    ddrphy_dll_update_arb_if bus_if ();

    ddrphy_dll_update_arb #(
        .UPDATE_PERIOD (PER),
        .FREEZE_HOLD   (FH),
        .UPD_PULSE     (UP)
    ) dut (
        .clk          (clk),
        .ddr_rstn_key (rstn),
        .bus          (bus_if.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: a sequence is a run of LEN cycles indexed by position
    bit m_seq, m_ack, m_src_rst, m_pend, m_lk1, m_lk2;
    int m_pos, m_timer, m_count;

    task automatic model_reset();
        m_seq = 0; m_ack = 0; m_src_rst = 0; m_pend = 0;
        m_lk1 = 0; m_lk2 = 0; m_pos = 0; m_timer = 0; m_count = 0;
    endtask

    task automatic model_step();
        bit qual, done, old_pend, np;
        int nt;
        qual     = m_lk2;
        old_pend = m_pend;
        m_lk2    = m_lk1;
        m_lk1    = bus_if.dll_lock;
        done     = m_seq && (m_pos == LEN - 1);
        if (!bus_if.periodic_en || done) begin
            nt = 0; np = 0;
        end else if (old_pend) begin
            nt = m_timer; np = 1;
        end else if (m_timer == PER - 1) begin
            nt = 0; np = 1;
        end else begin
            nt = m_timer + 1; np = 0;
        end
        if (m_seq) begin
            if (done) begin
                m_seq   = 0;
                m_count = (m_count + 1) % 256;
                m_ack   = m_src_rst && bus_if.rst_req;
            end else begin
                m_pos++;
            end
        end else if (m_ack) begin
            if (!bus_if.rst_req) m_ack = 0;
        end else if (bus_if.rst_req && qual) begin
            m_seq = 1; m_pos = 0; m_src_rst = 1;
        end else if (old_pend && bus_if.ctrl_idle && qual) begin
            m_seq = 1; m_pos = 0; m_src_rst = 0;
        end
        m_timer = nt;
        m_pend  = np;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".freeze"}, bus_if.dll_freeze, int'(m_seq));
        chk({tag, ".update"}, bus_if.dll_update, int'(m_seq && m_pos >= FH && m_pos < FH + UP));
        chk({tag, ".busy"},   bus_if.upd_busy,   int'(m_seq));
        chk({tag, ".ack"},    bus_if.rst_ack,    int'(m_ack));
        chk({tag, ".count"},  bus_if.upd_count,  m_count);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    int n;
    int c0;

    initial begin
        bus_if.rst_req     = 0;
        bus_if.periodic_en = 0;
        bus_if.ctrl_idle   = 0;
        bus_if.dll_lock    = 0;
        rstn = 0;
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        rstn = 1;

        // Reset-path update with ack hold
        bus_if.dll_lock = 1;
        repeat (10) tick("t1_wait");
        bus_if.rst_req = 1;
        repeat (20) tick("t1_seq");
        chk("t1_ack_high", bus_if.rst_ack, 1);
        bus_if.rst_req = 0;
        repeat (3) tick("t1_ack");
        chk("t1_count", bus_if.upd_count, 1);

        // Periodic updates with the controller idle
        bus_if.periodic_en = 1;
        bus_if.ctrl_idle   = 1;
        repeat (3 * (PER + LEN + 1) + 10) tick("t2");
        chk("t2_count", bus_if.upd_count, 4);

        // Controller busy holds off a pending periodic update
        bus_if.ctrl_idle = 0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick("t3_gated");
            if (bus_if.dll_freeze) n++;
        end
        chk("t3_no_freeze", n, 0);
        bus_if.ctrl_idle = 1;
        tick("t3_open");
        chk("t3_freeze_rise", bus_if.dll_freeze, 1);
        repeat (LEN + 2) tick("t3_tail");

        // Reset request and pending qualified together
        bus_if.ctrl_idle = 0;
        repeat (PER + 10) tick("t4_arm");
        c0 = m_count;
        bus_if.rst_req   = 1;
        bus_if.ctrl_idle = 1;
        repeat (LEN + 3) tick("t4_seq");
        chk("t4_ack", bus_if.rst_ack, 1);
        bus_if.rst_req = 0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick("t4_after");
            if (bus_if.dll_freeze) n++;
        end
        chk("t4_no_second", n, 0);
        chk("t4_count", bus_if.upd_count, (c0 + 1) % 256);

        // Lock gating and a lock drop in the middle of UPDATE
        bus_if.periodic_en = 0;
        bus_if.dll_lock    = 0;
        repeat (3) tick("t5_unlock");
        bus_if.rst_req = 1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick("t5_nolock");
            if (bus_if.dll_freeze) n++;
        end
        chk("t5_no_start", n, 0);
        bus_if.dll_lock = 1;
        repeat (2) tick("t5_sync");
        chk("t5_not_yet", bus_if.dll_freeze, 0);
        tick("t5_start");
        chk("t5_start", bus_if.dll_freeze, 1);
        n = 1;
        repeat (FH) begin
            tick("t5_pre");
            if (bus_if.dll_freeze) n++;
        end
        chk("t5_in_update", bus_if.dll_update, 1);
        bus_if.dll_lock = 0;
        repeat (LEN + 2) begin
            tick("t5_drop");
            if (bus_if.dll_freeze) n++;
        end
        chk("t5_len", n, LEN);
        bus_if.rst_req = 0;
        repeat (3) tick("t5_end");

        // Asynchronous reset in the middle of UPDATE
        bus_if.dll_lock = 1;
        repeat (3) tick("t6_lock");
        bus_if.rst_req = 1;
        repeat (FH + 2) tick("t6_run");
        chk("t6_pre_update", bus_if.dll_update, 1);
        rstn = 0;
        model_reset();
        #1;
        chk("t6_freeze0", bus_if.dll_freeze, 0);
        chk("t6_update0", bus_if.dll_update, 0);
        chk("t6_busy0",   bus_if.upd_busy,   0);
        chk("t6_count0",  bus_if.upd_count,  0);
        repeat (2) @(negedge clk);
        rstn = 1;
        n = 0;
        repeat (LEN + 6) begin
            tick("t6_restart");
            if (bus_if.dll_freeze) n++;
        end
        chk("t6_full_seq", n, LEN);
        bus_if.rst_req = 0;
        repeat (3) tick("t6_end");

        // Random traffic against the model
        bus_if.periodic_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) bus_if.rst_req = ~bus_if.rst_req;
            if ($urandom_range(199) == 0) bus_if.periodic_en = ~bus_if.periodic_en;
            if ($urandom_range(59) == 0) bus_if.dll_lock = ~bus_if.dll_lock;
            bus_if.ctrl_idle = ($urandom_range(3) != 0);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
